lane_sequencer: RTL and testbench

LANE_SEQUENCER -- requirements
Module: lane_sequencer

---
 rtl/lane_pkg.sv | 35 +++
 rtl/lane_sequencer_if.sv | 29 ++
 rtl/lane_mux.sv | 33 +++
 rtl/lane_sequencer.sv | 82 ++++++++
 tb/tb_lane_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_pkg.sv
// Shared types and the set-bit search used by the lane sequencer.
// The search walks the mask from the top down so the lowest qualifying lane wins.
package lane_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [3:0]        lane_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } lane_sel_t;

  // Lowest set bit of m at or above position 'from'; found=0 when none exists.
  // A 'from' past the top lane yields found=0, so the pointer can never wrap.
  function automatic lane_sel_t find_set(input logic [LANES-1:0] m, input int from);
    lane_sel_t r;
    r = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        r.found = 1'b1;
        r.idx   = lane_idx_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_sequencer_if.sv
// Upstream word handshake and downstream lane-beat handshake of the lane sequencer.
// master = the environment driving words in and taking beats out; slave = the sequencer.
interface lane_sequencer_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   in_data;
  logic [LANES-1:0]          in_mask;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANE_W-1:0]         out_data;
  logic [$clog2(LANES)-1:0]  out_lane;
  logic                      out_last;
  logic                      drop;

  modport master (
    output in_valid, in_data, in_mask, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, drop
  );

  modport slave (
    input  in_valid, in_data, in_mask, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, drop
  );

endinterface

// File: rtl/lane_mux.sv
// Combinational 16:1 lane select out of a captured result word.
module lane_mux
  import lane_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] word,
  input  lane_idx_t               sel,
  output lane_t                   lane
);

  always_comb begin
    lane = '0;
    case (sel)
      4'd0:    lane = word[ 0*LANE_W +: LANE_W];
      4'd1:    lane = word[ 1*LANE_W +: LANE_W];
      4'd2:    lane = word[ 2*LANE_W +: LANE_W];
      4'd3:    lane = word[ 3*LANE_W +: LANE_W];
      4'd4:    lane = word[ 4*LANE_W +: LANE_W];
      4'd5:    lane = word[ 5*LANE_W +: LANE_W];
      4'd6:    lane = word[ 6*LANE_W +: LANE_W];
      4'd7:    lane = word[ 7*LANE_W +: LANE_W];
      4'd8:    lane = word[ 8*LANE_W +: LANE_W];
      4'd9:    lane = word[ 9*LANE_W +: LANE_W];
      4'd10:   lane = word[10*LANE_W +: LANE_W];
      4'd11:   lane = word[11*LANE_W +: LANE_W];
      4'd12:   lane = word[12*LANE_W +: LANE_W];
      4'd13:   lane = word[13*LANE_W +: LANE_W];
      4'd14:   lane = word[14*LANE_W +: LANE_W];
      4'd15:   lane = word[15*LANE_W +: LANE_W];
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/lane_sequencer.sv
// Serialises the enabled lanes of each accepted result word into one beat per
// cycle, lowest lane first; all-zero masks are dropped with a one-cycle pulse.
module lane_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  lane_sequencer_if.slave  bus
);

  lane_pkg::state_t        state_p0;
  logic [LANES*LANE_W-1:0] word_p0;
  logic [LANES-1:0]        mask_p0;
  lane_pkg::lane_idx_t     ptr_p0;
  logic                    drop_p0;

  lane_pkg::lane_sel_t     first_sel;
  lane_pkg::lane_sel_t     next_sel;
  lane_pkg::lane_t         lane_val;
  logic                    sending;
  logic                    last;
  logic                    beat;
  logic                    rdy;
  logic                    accept;

  lane_mux u_mux (
    .word (word_p0),
    .sel  (ptr_p0),
    .lane (lane_val)
  );

  always_comb begin
    first_sel = lane_pkg::find_set(bus.in_mask, 0);
    next_sel  = lane_pkg::find_set(mask_p0, int'(ptr_p0) + 1);
    sending   = (state_p0 == lane_pkg::SEND);
    last      = sending && !next_sel.found;
    beat      = sending && bus.out_ready;
    // A new word may land on the same edge that retires the final beat.
    rdy       = !reset && (!sending || (last && bus.out_ready));
    accept    = bus.in_valid && rdy;
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = sending;
  assign bus.out_data  = sending ? lane_val : '0;
  assign bus.out_lane  = sending ? ptr_p0 : '0;
  assign bus.out_last  = last;
  assign bus.drop      = drop_p0;

  // Stage p0: capture word/mask and walk the lane pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= lane_pkg::IDLE;
      ptr_p0   <= '0;
      mask_p0  <= '0;
      word_p0  <= '0;
      drop_p0  <= 1'b0;
    end else begin
      drop_p0 <= 1'b0;
      if (accept) begin
        word_p0 <= bus.in_data;
        mask_p0 <= bus.in_mask;
        if (first_sel.found) begin
          state_p0 <= lane_pkg::SEND;
          ptr_p0   <= first_sel.idx;
        end else begin
          state_p0 <= lane_pkg::IDLE;
          ptr_p0   <= '0;
          drop_p0  <= 1'b1;
        end
      end else if (beat) begin
        if (last) begin
          state_p0 <= lane_pkg::IDLE;
        end else begin
          ptr_p0 <= next_sel.idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_sequencer.sv
// Bench for lane_sequencer: directed scenarios plus randomized traffic, all
// checked against a queue-of-expected-beats model of the sequencer.
module tb_lane_sequencer;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  lane;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_sequencer_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t expq[$];
  logic  exp_drop = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  // Every enabled lane of a word becomes one beat, lowest lane first.
  task automatic push_word(input logic [255:0] d, input logic [15:0] m);
    int    hi;
    beat_t b;
    hi = -1;
    for (int k = 0; k < 16; k++) if (m[k]) hi = k;
    for (int k = 0; k < 16; k++) begin
      if (m[k]) begin
        b.data = d[16*k +: 16];
        b.lane = 4'(k);
        b.last = (k == hi);
        expq.push_back(b);
      end
    end
  endtask

  function automatic logic exp_in_ready();
    return !reset && (expq.size() == 0 || (expq.size() == 1 && bus.out_ready));
  endfunction

  function automatic logic [23:0] exp_vec();
    if (expq.size() > 0)
      return {1'b1, expq[0].data, expq[0].lane, expq[0].last, exp_in_ready(), exp_drop};
    return {1'b0, 16'h0, 4'h0, 1'b0, exp_in_ready(), exp_drop};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {bus.out_valid, bus.out_data, bus.out_lane, bus.out_last, bus.in_ready, bus.drop};
  endfunction

  // Advance the model across one rising edge, then move to just after it.
  task automatic tick();
    logic acc;
    logic nd;
    nd = 1'b0;
    if (reset) begin
      expq.delete();
    end else begin
      acc = bus.in_valid && exp_in_ready();
      if (expq.size() > 0 && bus.out_ready) void'(expq.pop_front());
      if (acc) begin
        nd = (bus.in_mask == 16'h0);
        push_word(bus.in_data, bus.in_mask);
      end
    end
    @(posedge clk);
    #1;
    exp_drop = nd;
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_mask = 16'hFFFF; bus.in_data = rand_word(); bus.out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    vectors++;
    if (obs_vec() !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_held: got %h want %h", obs_vec(), 24'h0);
    end
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs_vec() !== 24'h000002) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), 24'h000002);
    end
    tick();
  endtask

  task automatic test_full_mask();
    logic [255:0] d;
    int beats, last_lane;
    beats = 0; last_lane = -1;
    for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'h1000 + 16'(k);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.in_valid = (i == 0); bus.in_data = d; bus.in_mask = 16'hFFFF;
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_mask cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.out_valid && bus.out_ready) beats++;
      if (bus.out_valid && bus.out_last) last_lane = int'(bus.out_lane);
      tick();
    end
    vectors++;
    if (beats !== 16 || last_lane !== 15) begin
      miscompares++;
      $display("FAIL full_mask_count: got beats %0d last %0d want 16 and 15", beats, last_lane);
    end
  endtask

  task automatic test_sparse();
    int beats;
    beats = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = (i == 0); bus.in_data = rand_word(); bus.in_mask = 16'h8421;
      if (i == 0) begin
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL sparse cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.out_valid) beats++;
      tick();
    end
    vectors++;
    if (beats !== 4) begin
      miscompares++;
      $display("FAIL sparse_count: got %0d beats want 4", beats);
    end
  endtask

  task automatic test_drop();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = (i == 0); bus.in_data = rand_word(); bus.in_mask = 16'h0000;
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL drop cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      vectors++;
      if (i == 1 && (bus.drop !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)) begin
        miscompares++;
        $display("FAIL drop_pulse: got drop %b valid %b ready %b want 1 0 1",
                 bus.drop, bus.out_valid, bus.in_ready);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i == 0); bus.in_data = rand_word(); bus.in_mask = 16'h0003;
      bus.out_ready = (i >= 4);
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL backpressure cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i >= 1 && i <= 3) begin
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_lane !== 4'd0 || bus.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL backpressure_hold cyc%0d: got ready %b lane %0d valid %b want 0 0 1",
                   i, bus.in_ready, bus.out_lane, bus.out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      d = rand_word();
      d[15:0] = 16'hB000 + 16'(i);
      bus.in_valid = (i < 4); bus.in_data = d; bus.in_mask = 16'h0001;
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i >= 1 && i <= 4) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hB000 + 16'(i - 1)) begin
          miscompares++;
          $display("FAIL back_to_back_bubble cyc%0d: got valid %b data %h want 1 %h",
                   i, bus.out_valid, bus.out_data, 16'hB000 + 16'(i - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i == 0); bus.in_data = rand_word(); bus.in_mask = 16'hFFFF;
      reset = (i == 4);
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        vectors++;
        if (obs_vec() !== 24'h000002) begin
          miscompares++;
          $display("FAIL reset_mid_clear: got %h want %h", obs_vec(), 24'h000002);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
      tick();
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_abandon: got %0d stray beats want 0", stray);
    end
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       m = 16'h0000;
        1:       m = 16'h0001 << $urandom_range(0, 15);
        2:       m = 16'hFFFF;
        default: m = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 59) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data = rand_word();
      bus.in_mask = m;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mask = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_mask();
    test_sparse();
    test_drop();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
